// File: rtl/codec_sample_sink.sv
// Codec-side sample sink: paces sample requests, captures returned samples and streams them as I2S.
// Build option SINK_MUTE_ON_UNDERRUN_EN: clear the held sample on underrun so the next frame is silence.
module codec_sample_sink #(
    parameter int unsigned CLK_DIV  = 2083,
    parameter int unsigned BCLK_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        new_sample_ready,
    output logic        generate_next_sample,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        sample_tick,
    output logic [7:0]  underrun_count
);

    localparam int unsigned CNT_W  = $clog2(CLK_DIV);
    localparam int unsigned BCLK_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(CLK_DIV - 2);
    localparam logic [BCLK_W-1:0] BCLK_LAST = BCLK_W'(BCLK_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // One-bit I2S delay, sample left-justified in each 32-bit slot, same sample in both slots.
    function automatic logic [63:0] build_frame(input logic [15:0] smp);
        return {1'b0, smp, 15'b0, 1'b0, smp, 15'b0};
    endfunction

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic [15:0]       hold_q, hold_d;
    logic [7:0]        urun_q, urun_d;
    logic [63:0]       sh_q, sh_d;
    logic [BCLK_W-1:0] div_q, div_d;
    logic [5:0]        bit_q, bit_d;
    logic              active_q, active_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              sdata_q, sdata_d;

    // Sample-period counter; the tick flag is registered one count early so it is high at CLK_DIV-1.
    always_comb begin
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tick_d = (cnt_q == CNT_PRE);
    end

    // Request FSM, sample capture and underrun accounting.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        urun_d  = urun_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_q) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (new_sample_ready) begin
                    hold_d  = sample_in;
                    state_d = tick_q ? ST_REQ : ST_IDLE;
                end else if (tick_q) begin
                    // Abandon the outstanding request and ask again.
                    state_d = ST_REQ;
                    if (urun_q != 8'hFF) begin
                        urun_d = urun_q + 8'd1;
                    end else begin
                        urun_d = urun_q;
                    end
`ifdef SINK_MUTE_ON_UNDERRUN_EN
                    hold_d = 16'h0000;
`else
                    hold_d = hold_q;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d = (state_d == ST_REQ);
    end

    // Frame serializer: loads on tick, shifts out one bit per bclk period on falling edges.
    always_comb begin
        sh_d     = sh_q;
        div_d    = div_q;
        bit_d    = bit_q;
        active_d = active_q;
        bclk_d   = bclk_q;
        lrclk_d  = lrclk_q;
        sdata_d  = sdata_q;
        if (tick_q) begin
            sh_d     = build_frame(hold_q);
            sdata_d  = sh_d[63];
            div_d    = '0;
            bit_d    = 6'd0;
            active_d = 1'b1;
            bclk_d   = 1'b0;
            lrclk_d  = 1'b0;
        end else if (active_q) begin
            if (div_q == BCLK_LAST) begin
                div_d = '0;
                if (!bclk_q) begin
                    bclk_d = 1'b1;
                end else begin
                    bclk_d = 1'b0;
                    if (bit_q == 6'd63) begin
                        active_d = 1'b0;
                        lrclk_d  = 1'b0;
                        sdata_d  = 1'b0;
                    end else begin
                        bit_d   = bit_q + 6'd1;
                        sh_d    = {sh_q[62:0], 1'b0};
                        sdata_d = sh_q[62];
                        lrclk_d = (bit_q >= 6'd31);
                    end
                end
            end else begin
                div_d = div_q + BCLK_W'(1);
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            hold_q   <= 16'h0000;
            urun_q   <= 8'd0;
            sh_q     <= 64'd0;
            div_q    <= '0;
            bit_q    <= 6'd0;
            active_q <= 1'b0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            state_q  <= state_d;
            req_q    <= req_d;
            hold_q   <= hold_d;
            urun_q   <= urun_d;
            sh_q     <= sh_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
        end
    end

    assign generate_next_sample = req_q;
    assign sample_tick          = tick_q;
    assign underrun_count       = urun_q;
    assign bclk                 = bclk_q;
    assign lrclk                = lrclk_q;
    assign sdata                = sdata_q;

endmodule

// File: tb/tb_codec_sample_sink.sv
// Self-checking bench for codec_sample_sink with CLK_DIV=300, BCLK_DIV=2.
module tb_codec_sample_sink;
    localparam int unsigned CD = 300;
    localparam int unsigned BD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        nsr = 1'b0;
    logic        generate_next_sample, bclk, lrclk, sdata, sample_tick;
    logic [7:0]  underrun_count;

    codec_sample_sink #(.CLK_DIV(CD), .BCLK_DIV(BD)) dut (
        .clk                  (clk),
        .reset                (reset),
        .sample_in            (sample_in),
        .new_sample_ready     (nsr),
        .generate_next_sample (generate_next_sample),
        .bclk                 (bclk),
        .lrclk                (lrclk),
        .sdata                (sdata),
        .sample_tick          (sample_tick),
        .underrun_count       (underrun_count)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; equals the DUT period counter value.
    int unsigned cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int vec_cnt = 0;
    int err_cnt = 0;
    bit mon_en = 1'b0;
    logic [63:0] exp_q[$];

    function automatic logic [63:0] frame_of(input logic [15:0] s);
        return {1'b0, s, 15'b0, 1'b0, s, 15'b0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    endtask

    // Per-cycle pacing checks plus frame capture against the scoreboard queue.
    logic        collecting = 1'b0;
    int unsigned load_cyc;
    logic [63:0] got, fexp;
    logic        lr_bad, bclk_bad;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                collecting = 1'b0;
            end else if (mon_en) begin
                check("sample_tick", sample_tick, (cyc % CD == CD - 1));
                check("gen_next", generate_next_sample, (cyc != 0 && cyc % CD == 0));
                if (collecting) begin
                    for (int i = 0; i < 64; i++) begin
                        if (cyc == load_cyc + 1 + 2*BD*i + BD) begin
                            got[63-i] = sdata;
                            if (bclk !== 1'b1) bclk_bad = 1'b1;
                            if (lrclk !== (i >= 32)) lr_bad = 1'b1;
                        end
                    end
                    if (cyc == load_cyc + 1 + 2*BD*63 + BD) begin
                        check("frame_sdata", got, fexp);
                        check("frame_lrclk_err", lr_bad, 1'b0);
                        check("frame_bclk_err", bclk_bad, 1'b0);
                    end
                    if (cyc == load_cyc + 3 + 2*BD*64) begin
                        check("idle_outputs", {bclk, lrclk, sdata}, 3'b000);
                        collecting = 1'b0;
                    end
                end
                if (sample_tick === 1'b1 && exp_q.size() > 0) begin
                    fexp       = exp_q.pop_front();
                    load_cyc   = cyc;
                    got        = 64'd0;
                    lr_bad     = 1'b0;
                    bclk_bad   = 1'b0;
                    collecting = 1'b1;
                end
            end
        end
    end

    // mode 0: no response (underrun); 1: one-cycle pulse 'delay' cycles after request; 2: hold high.
    typedef struct {
        int          mode;
        int          delay;
        logic [15:0] smp;
        logic [7:0]  exp_urun;
    } vec_t;
    vec_t tbl[8];

    task automatic wait_req();
        int n = 0;
        while (generate_next_sample !== 1'b1 && n < 2*CD) begin
            @(negedge clk);
            n++;
        end
        if (generate_next_sample !== 1'b1) begin
            err_cnt++;
            $display("FAIL req_timeout: no generate_next_sample within %0d cycles", 2*CD);
            finish_run();
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() > 0 || collecting) && n < 3*CD) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0 || collecting) begin
            err_cnt++;
            $display("FAIL drain_timeout: %0d frames still pending", exp_q.size());
            finish_run();
        end
    endtask

    logic [15:0] hold_m;
    int n;

    initial begin
        tbl[0] = '{1, 5,   16'hA5C3, 8'd0};
        tbl[1] = '{0, 0,   16'h0000, 8'd1};
        tbl[2] = '{0, 0,   16'h0000, 8'd2};
        tbl[3] = '{0, 0,   16'h0000, 8'd3};
        tbl[4] = '{1, 299, 16'h1234, 8'd3};
        tbl[5] = '{2, 0,   16'h5A5A, 8'd3};
        tbl[6] = '{1, 100, 16'h8001, 8'd3};
        tbl[7] = '{1, 298, 16'h7FFF, 8'd3};

        @(negedge clk);
        check("reset_outputs", {generate_next_sample, bclk, lrclk, sdata, sample_tick, underrun_count}, 13'd0);
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        hold_m = 16'h0000;
        exp_q.push_back(frame_of(16'h0000));

        for (int r = 0; r < 8; r++) begin
            wait_req();
            nsr = 1'b0;
            if (r == 0) check("first_req_cycle", cyc, CD);
            else        check("underrun_count", underrun_count, tbl[r-1].exp_urun);
            case (tbl[r].mode)
                0: begin
                    exp_q.push_back(frame_of(hold_m));
`ifdef SINK_MUTE_ON_UNDERRUN_EN
                    hold_m = 16'h0000;
`endif
                    @(negedge clk);
                end
                1: begin
                    if (tbl[r].delay < CD - 1) exp_q.push_back(frame_of(tbl[r].smp));
                    else                       exp_q.push_back(frame_of(hold_m));
                    hold_m = tbl[r].smp;
                    repeat (tbl[r].delay) @(negedge clk);
                    sample_in = tbl[r].smp;
                    nsr = 1'b1;
                    @(negedge clk);
                    nsr = 1'b0;
                    sample_in = ~tbl[r].smp;
                end
                default: begin
                    exp_q.push_back(frame_of(tbl[r].smp));
                    hold_m = tbl[r].smp;
                    sample_in = tbl[r].smp;
                    nsr = 1'b1;
                    repeat (3) @(negedge clk);
                    sample_in = ~tbl[r].smp;
                end
            endcase
        end

        wait_drain();
        check("urun_after_table", underrun_count, 8'd3);

        // Next tick is an underrun; then reset in the middle of bit 20 of that frame.
        n = 0;
        while (sample_tick !== 1'b1 && n < 2*CD) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", sample_tick, 1'b1);
        repeat (1 + 2*BD*20 + BD) @(negedge clk);
        check("mid_frame_bclk", bclk, 1'b1);
        check("urun_before_reset", underrun_count, 8'd4);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_outputs", {generate_next_sample, bclk, lrclk, sdata, sample_tick, underrun_count}, 13'd0);
        repeat (3) @(negedge clk);
        check("held_reset_outputs", {generate_next_sample, bclk, lrclk, sdata, sample_tick, underrun_count}, 13'd0);
        reset = 1'b1;
        exp_q.push_back(frame_of(16'h0000));
        wait_req();
        check("req_cycle_after_reset", cyc, CD);
        check("urun_after_reset", underrun_count, 8'd0);
        @(negedge clk);
        wait_drain();
        finish_run();
    end
endmodule
